// File: rtl/digit_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : digit_pair_loader
//  Purpose  : Captures two BCD digits entered serially with an Enter key,
//             holds them as operands A/B for the downstream swapper, and
//             computes the swap decision. Includes key synchronizers, an
//             inter-digit timeout and a Clear function.
//  Revision : 1.0  initial release
// ============================================================================
module digit_pair_loader #(
    parameter int TIMEOUT_CYCLES = 1000,   // legal range 2..65535
    parameter bit DESCENDING     = 1'b0    // 0: swap when A > B, 1: swap when A < B
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [3:0] digitIn,
    input  logic       enterKey,
    input  logic       clearKey,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       toSwap,
    output logic       pairValid,
    output logic       waitingB,
    output logic       errPulse
);

    // Counter only has to reach TIMEOUT_CYCLES-1, so ceil(log2) bits suffice.
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_B = 2'd1,
        S_READY  = 2'd2
    } state_t;

    // Synchronizer and history flops for the two raw keys
    logic enter_s1_q, enter_s2_q, enter_hist_q;
    logic clear_s1_q, clear_s2_q, clear_hist_q;

    logic enter_edge, clear_edge, digit_legal, timeout_hit;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic             toswap_q, toswap_d;
    logic             pvalid_q, pvalid_d;
    logic             waitb_q, waitb_d;
    logic             err_q, err_d;

    // Two-stage synchronizers plus history flop for rising-edge detection
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            enter_s1_q   <= 1'b0;
            enter_s2_q   <= 1'b0;
            enter_hist_q <= 1'b0;
            clear_s1_q   <= 1'b0;
            clear_s2_q   <= 1'b0;
            clear_hist_q <= 1'b0;
        end else begin
            enter_s1_q   <= enterKey;
            enter_s2_q   <= enter_s1_q;
            enter_hist_q <= enter_s2_q;
            clear_s1_q   <= clearKey;
            clear_s2_q   <= clear_s1_q;
            clear_hist_q <= clear_s2_q;
        end
    end

    assign enter_edge  = enter_s2_q & ~enter_hist_q;
    assign clear_edge  = clear_s2_q & ~clear_hist_q;
    assign digit_legal = (digitIn <= 4'd9);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; Clear beats Enter, Enter beats timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        a_d      = a_q;
        b_d      = b_q;
        toswap_d = toswap_q;
        pvalid_d = pvalid_q;
        err_d    = 1'b0;

        if (clear_edge) begin
            state_d  = S_IDLE;
            a_d      = 4'd0;
            b_d      = 4'd0;
            toswap_d = 1'b0;
            pvalid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enter_edge) begin
                        if (digit_legal) begin
                            a_d      = digitIn;
                            b_d      = 4'd0;
                            toswap_d = 1'b0;
                            pvalid_d = 1'b0;
                            state_d  = S_WAIT_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WAIT_B: begin
                    if (enter_edge && digit_legal) begin
                        b_d      = digitIn;
                        toswap_d = DESCENDING ? (a_q < digitIn) : (a_q > digitIn);
                        pvalid_d = 1'b1;
                        state_d  = S_READY;
                    end else begin
                        // Illegal digit and timeout merge into one error cycle
                        if (enter_edge) begin
                            err_d = 1'b1;
                        end
                        if (timeout_hit) begin
                            err_d   = 1'b1;
                            a_d     = 4'd0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_READY: begin
                    // B/toSwap stay frozen; only pairValid drops on a new first digit
                    if (enter_edge) begin
                        if (digit_legal) begin
                            a_d      = digitIn;
                            pvalid_d = 1'b0;
                            state_d  = S_WAIT_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        waitb_d = (state_d == S_WAIT_B);
    end

    // State, operand and flag registers; every output comes from here
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            toswap_q <= 1'b0;
            pvalid_q <= 1'b0;
            waitb_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            toswap_q <= toswap_d;
            pvalid_q <= pvalid_d;
            waitb_q  <= waitb_d;
            err_q    <= err_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign toSwap    = toswap_q;
    assign pairValid = pvalid_q;
    assign waitingB  = waitb_q;
    assign errPulse  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_pair_loader
//  Purpose  : Self-checking bench for digit_pair_loader. Two instances
//             (ascending / long timeout, descending / short timeout) share
//             the same stimulus and are compared every cycle against a
//             behavioural model of the digit-entry rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_digit_pair_loader;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] digitIn;
    logic       enterKey;
    logic       clearKey;

    logic [3:0] A0, B0, A1, B1;
    logic       ts0, pv0, wb0, er0, ts1, pv1, wb1, er1;

    always #5 clk = ~clk;

    digit_pair_loader #(.TIMEOUT_CYCLES(20), .DESCENDING(1'b0)) dut0 (
        .clk(clk), .rstN(rstN), .digitIn(digitIn), .enterKey(enterKey), .clearKey(clearKey),
        .A(A0), .B(B0), .toSwap(ts0), .pairValid(pv0), .waitingB(wb0), .errPulse(er0)
    );

    digit_pair_loader #(.TIMEOUT_CYCLES(8), .DESCENDING(1'b1)) dut1 (
        .clk(clk), .rstN(rstN), .digitIn(digitIn), .enterKey(enterKey), .clearKey(clearKey),
        .A(A1), .B(B1), .toSwap(ts1), .pairValid(pv1), .waitingB(wb1), .errPulse(er1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-instance operand/flag state plus elapsed time in WAIT_B
    int         m_tmo  [2] = '{20, 8};
    bit         m_desc [2] = '{1'b0, 1'b1};
    int         m_mode [2];   // 0 idle, 1 waiting for B, 2 pair ready
    int         m_wait [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    bit         m_ts   [2];
    bit         m_pv   [2];
    bit         m_er   [2];
    // Raw key samples from the last three clock edges (most recent first)
    bit e_h1, e_h2, e_h3, c_h1, c_h2, c_h3;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_wait[d] = 0; m_a[d] = 4'd0; m_b[d] = 4'd0;
            m_ts[d] = 1'b0; m_pv[d] = 1'b0; m_er[d] = 1'b0;
        end
        {e_h1, e_h2, e_h3, c_h1, c_h2, c_h3} = '0;
    endtask

    // A key press acts two edges after its raw rise is first sampled
    task automatic model_step();
        bit ee, ce, legal;
        int dig;
        ee    = e_h2 & ~e_h3;
        ce    = c_h2 & ~c_h3;
        dig   = int'(digitIn);
        legal = (dig <= 9);
        for (int d = 0; d < 2; d++) begin
            m_er[d] = 1'b0;
            if (ce) begin
                m_mode[d] = 0; m_wait[d] = 0; m_a[d] = 0; m_b[d] = 0; m_ts[d] = 0; m_pv[d] = 0;
            end else if (m_mode[d] == 0) begin
                if (ee && legal) begin
                    m_a[d] = digitIn; m_b[d] = 0; m_ts[d] = 0; m_pv[d] = 0;
                    m_mode[d] = 1; m_wait[d] = 0;
                end else if (ee) m_er[d] = 1'b1;
            end else if (m_mode[d] == 1) begin
                if (ee && legal) begin
                    m_b[d]  = digitIn;
                    m_ts[d] = m_desc[d] ? (int'(m_a[d]) < dig) : (int'(m_a[d]) > dig);
                    m_pv[d] = 1'b1; m_mode[d] = 2; m_wait[d] = 0;
                end else begin
                    if (ee) m_er[d] = 1'b1;
                    if (m_wait[d] == m_tmo[d] - 1) begin
                        m_er[d] = 1'b1; m_a[d] = 0; m_mode[d] = 0; m_wait[d] = 0;
                    end else m_wait[d]++;
                end
            end else begin
                if (ee && legal) begin
                    m_a[d] = digitIn; m_pv[d] = 0; m_mode[d] = 1; m_wait[d] = 0;
                end else if (ee) m_er[d] = 1'b1;
            end
        end
        e_h3 = e_h2; e_h2 = e_h1; e_h1 = enterKey;
        c_h3 = c_h2; c_h2 = c_h1; c_h1 = clearKey;
    endtask

    task automatic check_all();
        logic [3:0] oa [2], ob [2];
        logic       ots[2], opv[2], owb[2], oer[2];
        oa  = '{A0, A1};   ob  = '{B0, B1};
        ots = '{ts0, ts1}; opv = '{pv0, pv1};
        owb = '{wb0, wb1}; oer = '{er0, er1};
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("A[%0d]", d), oa[d], m_a[d]);
            chk($sformatf("pairValid[%0d]", d), {3'b0, opv[d]}, {3'b0, m_pv[d]});
            chk($sformatf("waitingB[%0d]", d), {3'b0, owb[d]}, {3'b0, m_mode[d] == 1});
            chk($sformatf("errPulse[%0d]", d), {3'b0, oer[d]}, {3'b0, m_er[d]});
            if (m_pv[d]) begin
                chk($sformatf("B[%0d]", d), ob[d], m_b[d]);
                chk($sformatf("toSwap[%0d]", d), {3'b0, ots[d]}, {3'b0, m_ts[d]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstN) model_reset();
        else       model_step();
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] dig, input int hold, input int gap);
        digitIn  = dig;
        enterKey = 1'b1;
        repeat (hold) tick();
        enterKey = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        rstN = 1'b0; digitIn = 4'd0; enterKey = 1'b0; clearKey = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_A", A0, 4'd0);
        chk("rst_flags", {er0, wb0, pv0, ts0}, 4'd0);
        rstN = 1'b1;
        repeat (2) tick();

        // 7 then 3, rises 10 cycles apart
        press(4'd7, 2, 8);
        chk("w_waitB", {3'b0, wb0}, 4'd1);
        press(4'd3, 2, 4);
        chk("p73_A", A0, 4'd7);
        chk("p73_B", B0, 4'd3);
        chk("p73_swap", {3'b0, ts0}, 4'd1);
        chk("p73_wait", {3'b0, wb0}, 4'd0);

        // Equal digits, then 4/9 on both polarities
        press(4'd2, 1, 4);
        press(4'd2, 1, 4);
        chk("eq_swap", {3'b0, ts0}, 4'd0);
        chk("eq_valid", {3'b0, pv0}, 4'd1);
        press(4'd4, 1, 4);
        press(4'd9, 1, 4);
        chk("d49_desc", {3'b0, ts1}, 4'd1);
        chk("d49_asc", {3'b0, ts0}, 4'd0);

        // Timeout on the short-timeout instance
        clearKey = 1'b1; tick(); clearKey = 1'b0; repeat (4) tick();
        press(4'd5, 1, 20);
        chk("tmo_A", A1, 4'd0);
        chk("tmo_valid", {3'b0, pv1}, 4'd0);

        // Illegal digit in IDLE, then a legal one
        clearKey = 1'b1; tick(); clearKey = 1'b0; repeat (4) tick();
        press(4'd12, 1, 4);
        chk("ill_A", A0, 4'd0);
        press(4'd6, 1, 3);
        chk("leg_A", A0, 4'd6);
        chk("leg_wait", {3'b0, wb0}, 4'd1);

        // Pair 8/1, then Enter and Clear together
        press(4'd8, 1, 3);
        press(4'd1, 1, 3);
        digitIn = 4'd9; enterKey = 1'b1; clearKey = 1'b1;
        repeat (3) tick();
        enterKey = 1'b0; clearKey = 1'b0;
        repeat (3) tick();
        chk("clr_A", A0, 4'd0);
        chk("clr_flags", {pv0, wb0, ts0, B0 != 4'd0}, 4'd0);

        // Enter held for 50 cycles gives one capture
        press(4'd4, 50, 4);

        // Asynchronous reset in WAIT_B
        clearKey = 1'b1; tick(); clearKey = 1'b0; repeat (4) tick();
        press(4'd5, 1, 4);
        #3;
        rstN = 1'b0;
        #1;
        model_reset();
        chk("arst_A", A0, 4'd0);
        chk("arst_flags", {1'b0, er0, wb0, wb1}, 4'd0);
        repeat (2) tick();
        rstN = 1'b1;
        repeat (2) tick();
        press(4'd6, 1, 3);
        chk("post_rst_A", A0, 4'd6);

        // Randomized entry with illegal digits, clears and varied spacing
        for (int i = 0; i < 300; i++) begin
            logic [3:0] dg;
            dg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) begin
                clearKey = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                clearKey = 1'b0;
            end
            press(dg, $urandom_range(1, 4), $urandom_range(1, 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_pair_loader.md
Name: digit_pair_loader

Overview:
- Upstream stage of the 4-bit value swapper in the digital-lock datapath.
- Captures two BCD digits entered serially from switches and an Enter key, and holds them as operands A and B.
- Computes the swap decision from A and B, and flags when a complete pair is ready.
- Outputs A, B and toSwap drive the swapper's A, B and toSwap inputs directly.

Parameters:
- TIMEOUT_CYCLES, 1000: clock cycles allowed between the first and second digit before the pair is abandoned; legal range 2..65535.
- DESCENDING, 0: 0 = toSwap asserted when A > B; 1 = toSwap asserted when A < B.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- digitIn  input  4  digit value from switches (BCD, 0..9 legal).
- enterKey  input  1  raw Enter key level, asynchronous to clk.
- clearKey  input  1  raw Clear key level, asynchronous to clk.
- A  output  4  first captured digit.
- B  output  4  second captured digit.
- toSwap  output  1  swap decision for the downstream swapper.
- pairValid  output  1  high while A/B/toSwap hold a complete pair.
- waitingB  output  1  high while waiting for the second digit.
- errPulse  output  1  one-cycle pulse on an illegal digit or a timeout.

Behaviour:
- Clock and reset: one clock domain; rstN is asynchronous active-low.
- Reset values: all outputs 0, FSM in IDLE, synchronizers 0, timeout counter 0. Reset asserted mid-operation aborts immediately; no partial pair survives.
- Input synchronization:
  - enterKey and clearKey each pass through a 2-FF synchronizer plus a history FF.
  - enterEdge = sync & ~hist; clearEdge likewise.
  - A raw rise sampled at clock edge n yields an edge pulse in the cycle after edge n+1; the action takes effect at edge n+2.
  - Level held high produces exactly one edge.
- digitIn is sampled directly at the acting edge. The user holds the switches stable while pressing Enter; digitIn is not synchronized.
- FSM states:
  - IDLE: enterEdge with a legal digit -> load A, clear B/toSwap/pairValid, go WAIT_B.
  - WAIT_B: enterEdge with a legal digit -> load B, compute toSwap, set pairValid, go READY.
  - WAIT_B: timeout counter reaches TIMEOUT_CYCLES-1 with no enterEdge -> pulse errPulse, zero A, go IDLE.
  - READY: enterEdge with a legal digit -> load A as a new first digit, drop pairValid, go WAIT_B. A/B/toSwap stay frozen until then.
- waitingB = (state == WAIT_B), registered.
- Illegal digit (digitIn > 9) at an acting enterEdge: no register or state change, errPulse for one cycle. In WAIT_B the timeout counter keeps running.
- toSwap is computed from the loaded A and the incoming digit in the same edge as B is loaded:
  - DESCENDING=0: A > digitIn.
  - DESCENDING=1: A < digitIn.
  - Equal values give toSwap=0.
- Timeout counter:
  - Cleared on entry to WAIT_B; increments each cycle in WAIT_B; held at 0 elsewhere.
  - Width is ceil(log2(TIMEOUT_CYCLES)); no wrap is possible.
- Clear: clearEdge in any state -> A=B=0, toSwap=0, pairValid=0, go IDLE, no errPulse.
- Priority, highest first:
  - rstN.
  - clearEdge over enterEdge.
  - enterEdge over timeout in the same cycle; a legal digit loads B, an illegal one pulses errPulse and the timeout still fires.
  - Simultaneous illegal-digit error and timeout give a single errPulse cycle.
- All outputs come directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset then enter 7 then 3, Enter pulses 10 cycles apart, DESCENDING=0 -> A=7, B=3, toSwap=1, pairValid=1 two edges after the second raw rise. waitingB high only between the two digits.
- Enter 2 then 2 -> toSwap=0, pairValid=1. Repeat with DESCENDING=1 and 4 then 9 -> toSwap=1.
- TIMEOUT_CYCLES=8: enter 5, then wait -> errPulse exactly one cycle 8 cycles after entering WAIT_B; A=0, state IDLE, pairValid=0.
- digitIn=12 with Enter in IDLE -> errPulse one cycle, A unchanged at 0, waitingB=0. Then enter 6 -> A=6, waitingB=1.
- Complete pair 8/1, then Enter and Clear asserted in the same cycle -> Clear wins: all outputs 0, IDLE. Enter held high for 50 cycles -> only one capture.
- Drop rstN asynchronously mid-WAIT_B, between clock edges -> A, waitingB and errPulse go 0 immediately. After release, the first Enter loads A.
